// File: rtl/adc_pkg.sv
// Shared definitions for the ADC front end: FSM state encoding and default
// sample width / reset code used by adc_sampler and its bench.
package adc_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int RESET_CODE_DEF = 128;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CONV    = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] WAIT_LO = 3'd3;
    localparam logic [2:0] READ    = 3'd4;
    localparam logic [2:0] ACC     = 3'd5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving asynchronously to clk.
// Both stages clear to 0 on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// Parallel-ADC front end: runs convst/busy/read handshake per trig, averages
// 2^AVG_LOG2 conversions into a held sample, flags busy timeouts and overruns.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int AVG_LOG2   = 0,
    parameter int CONV_LOW   = 2,
    parameter int RD_CYCLES  = 3,
    parameter int BUSY_TO    = 64,
    parameter int RESET_CODE = RESET_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              adc_busy,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_convst_n,
    output logic              adc_cs_n,
    output logic              adc_rd_n,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              err_timeout,
    output logic              overrun
);

    localparam int CNT_MAX = (CONV_LOW > RD_CYCLES) ? CONV_LOW : RD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int TO_W    = $clog2(BUSY_TO) + 1;
    localparam int AVG_W   = AVG_LOG2 + 1;
    localparam int ACC_W   = DATA_W + AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_LOW - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(BUSY_TO - 1);
    localparam logic [AVG_W-1:0] AVG_LAST  = AVG_W'((1 << AVG_LOG2) - 1);
    localparam logic [ACC_W-1:0] ROUND     = ACC_W'((1 << AVG_LOG2) >> 1);
    localparam logic [ACC_W-1:0] SAT_MAX   = ACC_W'((1 << DATA_W) - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] data_r;
    logic [ACC_W-1:0]  acc;
    logic [AVG_W-1:0]  avg_cnt;
    logic              busy_s;
    logic [ACC_W-1:0]  acc_new;
    logic [ACC_W-1:0]  rounded;

    sync_2ff #(.WIDTH(1)) u_busy_sync (
        .clk (clk),
        .rst (rst),
        .d   (adc_busy),
        .q   (busy_s)
    );

    // Round-half-up average; the extra acc bit keeps acc_new + ROUND from wrapping.
    always_comb begin
        acc_new = acc + ACC_W'(data_r);
        rounded = (acc_new + ROUND) >> AVG_LOG2;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; reset clears acc/avg_cnt, dropping a partial average.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            to_cnt       <= '0;
            adc_convst_n <= 1'b1;
            adc_cs_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            data_r       <= '0;
            acc          <= '0;
            avg_cnt      <= '0;
            sample       <= DATA_W'(RESET_CODE);
            sample_valid <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            err_timeout  <= 1'b0;
            if (trig && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (trig) begin
                        state        <= CONV;
                        adc_convst_n <= 1'b0;
                        cnt          <= '0;
                    end
                end
                CONV: begin
                    if (cnt == CONV_LAST) begin
                        adc_convst_n <= 1'b1;
                        to_cnt       <= '0;
                        state        <= WAIT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HI, WAIT_LO: begin
                    // Timeout is checked first so it wins over a late busy edge.
                    to_cnt <= to_cnt + 1'b1;
                    if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (state == WAIT_HI && busy_s) begin
                        state <= WAIT_LO;
                    end else if (state == WAIT_LO && !busy_s) begin
                        state    <= READ;
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                        cnt      <= '0;
                    end
                end
                READ: begin
                    if (cnt == RD_LAST) begin
                        adc_cs_n <= 1'b1;
                        adc_rd_n <= 1'b1;
                        data_r   <= adc_data;
                        state    <= ACC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACC: begin
                    state <= IDLE;
                    if (avg_cnt == AVG_LAST) begin
                        sample       <= (rounded > SAT_MAX) ? DATA_W'(SAT_MAX) : rounded[DATA_W-1:0];
                        sample_valid <= 1'b1;
                        acc          <= '0;
                        avg_cnt      <= '0;
                    end else begin
                        acc     <= acc_new;
                        avg_cnt <= avg_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: two instances (no averaging, 4-sample averaging) share
// one reactive ADC model; expected outputs come from a per-cycle timeline.
module tb_adc_sampler;

    localparam int CONV_LOW  = 2;
    localparam int RD_CYCLES = 3;
    localparam int BUSY_TO   = 64;
    localparam int MAXC      = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] adc_data = 8'h00;

    logic       cv0, cs0, rd0, sv0, to0, ov0;
    logic [7:0] s0;
    logic       cv2, cs2, rd2, sv2, to2, ov2;
    logic [7:0] s2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    // Expected timeline, indexed by cycle number.
    bit         e_cv[MAXC];
    bit         e_rd[MAXC];
    bit         e_v0[MAXC];
    bit         e_v2[MAXC];
    bit         e_to[MAXC];
    bit         e_ov[MAXC];
    logic [7:0] e_s0[MAXC];
    logic [7:0] e_s2[MAXC];
    int         pending[$];

    adc_sampler #(.AVG_LOG2(0), .CONV_LOW(CONV_LOW), .RD_CYCLES(RD_CYCLES), .BUSY_TO(BUSY_TO)) dut0 (
        .clk(clk), .rst(rst), .trig(trig), .adc_busy(busy), .adc_data(adc_data),
        .adc_convst_n(cv0), .adc_cs_n(cs0), .adc_rd_n(rd0), .sample(s0),
        .sample_valid(sv0), .err_timeout(to0), .overrun(ov0)
    );

    adc_sampler #(.AVG_LOG2(2), .CONV_LOW(CONV_LOW), .RD_CYCLES(RD_CYCLES), .BUSY_TO(BUSY_TO)) dut2 (
        .clk(clk), .rst(rst), .trig(trig), .adc_busy(busy), .adc_data(adc_data),
        .adc_convst_n(cv2), .adc_cs_n(cs2), .adc_rd_n(rd2), .sample(s2),
        .sample_valid(sv2), .err_timeout(to2), .overrun(ov2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear(input int from);
        for (int i = from; i < MAXC; i++) begin
            e_cv[i] = 1'b1; e_rd[i] = 1'b1; e_v0[i] = 1'b0; e_v2[i] = 1'b0;
            e_to[i] = 1'b0; e_ov[i] = 1'b0; e_s0[i] = 8'd128; e_s2[i] = 8'd128;
        end
        pending.delete();
    endtask

    task automatic compare();
        int c;
        c = cyc;
        if (c < MAXC) begin
            check("convst_n", cv0, e_cv[c]);
            check("convst_n_avg", cv2, e_cv[c]);
            check("cs_n", cs0, e_rd[c]);
            check("rd_n", rd0, e_rd[c]);
            check("rd_n_avg", rd2, e_rd[c]);
            check("sample_valid", sv0, e_v0[c]);
            check("sample_valid_avg", sv2, e_v2[c]);
            check("sample", s0, e_s0[c]);
            check("sample_avg", s2, e_s2[c]);
            check("err_timeout", to0, e_to[c]);
            check("err_timeout_avg", to2, e_to[c]);
            check("overrun", ov0, e_ov[c]);
            check("overrun_avg", ov2, e_ov[c]);
        end
    endtask

    // Advance one cycle from posedge+1 to the next posedge+1, comparing at negedge.
    task automatic tick();
        @(negedge clk);
        if (cmp_en) compare();
        @(posedge clk);
        #1;
    endtask

    // One trig plus ADC behaviour. hold<0: busy never falls. ovr_off/rst_off>0:
    // extra trig / reset at cycle k+offset. Caller sits at posedge+1.
    task automatic convert(input logic [7:0] d, input int hold, input int ovr_off,
                           input int rst_off, output int lat, output int to_gap);
        int k, c0, end_c, v, w, sum, avg;
        bit seen_lo;
        k = cyc; c0 = -1; seen_lo = 1'b0; lat = -1; to_gap = -1;
        adc_data = d;
        trig = 1'b1;

        for (int i = 1; i <= CONV_LOW; i++) e_cv[k+i] = 1'b0;
        if (hold >= 0) begin
            // busy rises one cycle after release, then each edge costs 2 sync cycles + 1 decision
            w = hold + 4;
            v = k + 1 + CONV_LOW + w + RD_CYCLES + 1;
            for (int i = v - 1 - RD_CYCLES; i <= v - 2; i++) e_rd[i] = 1'b0;
            e_v0[v] = 1'b1;
            for (int i = v; i < MAXC; i++) e_s0[i] = d;
            pending.push_back(int'(d));
            if (pending.size() == 4) begin
                sum = 0;
                foreach (pending[j]) sum += pending[j];
                avg = (sum + 2) / 4;
                if (avg > 255) avg = 255;
                e_v2[v] = 1'b1;
                for (int i = v; i < MAXC; i++) e_s2[i] = 8'(avg);
                pending.delete();
            end
            end_c = v;
        end else begin
            end_c = k + 1 + CONV_LOW + BUSY_TO;
            e_to[end_c] = 1'b1;
        end
        if (ovr_off > 0)
            for (int i = k + ovr_off + 1; i < MAXC; i++) e_ov[i] = 1'b1;

        for (int i = 0; i < 200; i++) begin
            tick();
            trig = (ovr_off > 0 && cyc == k + ovr_off);
            if (!seen_lo && cv0 == 1'b0) seen_lo = 1'b1;
            else if (seen_lo && c0 < 0 && cv0 == 1'b1) c0 = cyc;
            busy = (c0 >= 0) && (cyc > c0) && (hold < 0 || cyc <= c0 + hold);
            if (sv0 && lat < 0) lat = cyc - k;
            if (to0 && to_gap < 0 && c0 >= 0) to_gap = cyc - c0;
            if (rst_off > 0 && cyc == k + rst_off) begin
                check("rd_low_before_rst", rd0, 1'b0);
                cmp_en = 1'b0;
                busy = 1'b0;
                trig = 1'b0;
                rst = 1'b0;
                #1;
                check("rst_convst_n", cv0, 1'b1);
                check("rst_cs_n", cs0, 1'b1);
                check("rst_rd_n", rd0, 1'b1);
                check("rst_sample", s0, 8'd128);
                check("rst_sample_avg", s2, 8'd128);
                check("rst_sample_valid", sv0, 1'b0);
                check("rst_overrun", ov0, 1'b0);
                model_clear(cyc);
                break;
            end
            if (cyc >= end_c) break;
        end
        trig = 1'b0;
        busy = 1'b0;
    endtask

    initial begin
        int lat, tog;
        logic [7:0] held;
        int t3[4];
        int t7[4];
        t3 = '{10, 11, 12, 13};
        t7 = '{20, 40, 60, 80};

        model_clear(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cmp_en = 1'b1;
        repeat (4) tick();
        check("idle_sample", s0, 8'd128);
        check("idle_convst_n", cv0, 1'b1);
        check("idle_rd_n", rd0, 1'b1);
        check("idle_overrun", ov0, 1'b0);

        // Averaging of 10..13 rounds 46 up to 12.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("avg_not_yet", s2, 8'd128);
            convert(8'(t3[i]), 3, 0, 0, lat, tog);
            tick();
        end
        check("avg4_sample", s2, 8'd12);
        check("avg4_raw_last", s0, 8'd13);

        for (int i = 0; i < 4; i++) begin
            convert(8'hFF, 2, 0, 0, lat, tog);
        end
        tick();
        check("avg_full_scale", s2, 8'hFF);

        convert(8'hA7, 5, 0, 0, lat, tog);
        check("latency", lat, 16);
        check("sample_a7", s0, 8'hA7);

        for (int i = 0; i < 7; i++) begin
            convert(8'($urandom_range(0, 255)), $urandom_range(2, 8), 0, 0, lat, tog);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Extra trig while in WAIT_LO.
        convert(8'h3C, 5, 9, 0, lat, tog);
        tick();
        check("overrun_set", ov0, 1'b1);
        check("overrun_conv_done", s0, 8'h3C);

        // Busy stuck high, with a trig landing on the timeout edge.
        held = s0;
        convert(8'h55, -1, CONV_LOW + BUSY_TO, 0, lat, tog);
        check("timeout_gap", tog, BUSY_TO);
        repeat (3) tick();
        check("timeout_sample_held", s0, held);

        convert(8'h11, 4, 0, 0, lat, tog);
        tick();
        check("after_timeout_sample", s0, 8'h11);

        // Reset in the middle of READ; partial average must be dropped.
        convert(8'h99, 5, 0, 13, lat, tog);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cmp_en = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("post_rst_avg_not_yet", s2, 8'd128);
            convert(8'(t7[i]), 3, 0, 0, lat, tog);
        end
        repeat (3) tick();
        check("post_rst_avg", s2, 8'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
